// File: rtl/pooling_stream.sv
`default_nettype none
// ============================================================================
// Module   : pooling_stream
// Purpose  : Streaming pooling reducer. Folds a window of 2^win_log2 beats,
//            each LANES signed Q(IL).(FL) samples wide, into a single
//            max / mean / min / saturating-sum result. Both sides use
//            valid/ready handshakes.
// Ports    : clk, reset              - clock, synchronous active-high reset
//            in_data/in_valid/in_ready - input beat stream (lane 0 in LSBs)
//            mode                    - 00 max, 01 mean, 10 min, 11 sat sum
//            win_log2                - window = 2^win_log2 beats (clamped)
//            flush                   - drop the partial window
//            om/out_valid/out_ready  - result handshake
//            state                   - 00 IDLE, 01 ACCUM, 10 OUT
// Config   : POOL_ROUND_EN - mean uses round-half-up instead of truncation
// Revision : 1.0 - initial streaming release
// ============================================================================
module pooling_stream #(
    parameter int IL           = 4,
    parameter int FL           = 16,
    parameter int LANES        = 4,
    parameter int WIN_LOG2_MAX = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LANES*(IL+FL)-1:0]  in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                mode,
    input  logic [$clog2(WIN_LOG2_MAX+1)-1:0] win_log2,
    input  logic                      flush,
    output logic [IL+FL-1:0]          om,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [1:0]                state
);

    localparam int W          = IL + FL;
    localparam int LOG2_LANES = $clog2(LANES);
    localparam int ACC_W      = IL + FL + $clog2(LANES) + WIN_LOG2_MAX;
    localparam int WL_W       = $clog2(WIN_LOG2_MAX + 1);
    localparam int CNT_W      = $clog2((1 << WIN_LOG2_MAX) + 1);

    localparam logic [1:0] c_mode_max  = 2'b00;
    localparam logic [1:0] c_mode_mean = 2'b01;
    localparam logic [1:0] c_mode_min  = 2'b10;

    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_OUT   = 2'b10
    } state_t;

    state_t                    r_state;
    logic [1:0]                r_mode;
    logic [WL_W-1:0]           r_win;
    logic [CNT_W-1:0]          r_cnt;
    logic signed [ACC_W-1:0]   r_acc;
    logic [W-1:0]              r_om;

    logic [WL_W-1:0]           w_win_clamp;
    logic [WL_W-1:0]           w_win_eff;
    logic [1:0]                w_mode_eff;
    logic signed [W-1:0]       w_s;
    logic signed [W-1:0]       w_lane_max;
    logic signed [W-1:0]       w_lane_min;
    logic signed [ACC_W-1:0]   w_lane_sum;
    logic signed [ACC_W-1:0]   w_beat;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W:0]     w_pre;
    logic signed [ACC_W:0]     w_shifted;
    int unsigned               w_shift;
    logic [W-1:0]              w_result;
    logic                      w_seed;

    assign w_win_clamp = (win_log2 > WL_W'(WIN_LOG2_MAX)) ? WL_W'(WIN_LOG2_MAX) : win_log2;
    // The first beat of a window is folded using the live controls, which
    // are latched on that same edge; later beats use the latched copies.
    assign w_seed      = (r_state == S_IDLE);
    assign w_win_eff   = w_seed ? w_win_clamp : r_win;
    assign w_mode_eff  = w_seed ? mode : r_mode;

    // Per-beat lane reduction (max, min and full-precision sum).
    always_comb begin
        w_s        = in_data[W-1:0];
        w_lane_max = w_s;
        w_lane_min = w_s;
        w_lane_sum = {{(ACC_W-W){w_s[W-1]}}, w_s};
        for (int i = 1; i < LANES; i++) begin
            w_s = in_data[i*W +: W];
            if (w_s > w_lane_max) w_lane_max = w_s;
            if (w_s < w_lane_min) w_lane_min = w_s;
            w_lane_sum = w_lane_sum + {{(ACC_W-W){w_s[W-1]}}, w_s};
        end
    end

    // Combine the beat with the accumulator, then derive the final result
    // from the updated value so om can be captured on the last beat.
    always_comb begin
        case (w_mode_eff)
            c_mode_max: w_beat = {{(ACC_W-W){w_lane_max[W-1]}}, w_lane_max};
            c_mode_min: w_beat = {{(ACC_W-W){w_lane_min[W-1]}}, w_lane_min};
            default:    w_beat = w_lane_sum;
        endcase

        if (w_seed) begin
            w_acc_next = w_beat;
        end else begin
            case (w_mode_eff)
                c_mode_max: w_acc_next = (w_beat > r_acc) ? w_beat : r_acc;
                c_mode_min: w_acc_next = (w_beat < r_acc) ? w_beat : r_acc;
                default:    w_acc_next = r_acc + w_beat;
            endcase
        end

        w_shift = int'(w_win_eff) + LOG2_LANES;
        w_pre   = {w_acc_next[ACC_W-1], w_acc_next};
`ifdef POOL_ROUND_EN
        if (w_shift != 0) begin
            w_pre = w_pre + ((ACC_W+1)'(1) <<< (w_shift - 1));
        end
`endif
        w_shifted = w_pre >>> w_shift;

        case (w_mode_eff)
            c_mode_mean: w_result = w_shifted[W-1:0];
            c_mode_max,
            c_mode_min:  w_result = w_acc_next[W-1:0];
            default: begin
                if (w_acc_next > c_sat_max)      w_result = c_sat_max[W-1:0];
                else if (w_acc_next < c_sat_min) w_result = c_sat_min[W-1:0];
                else                             w_result = w_acc_next[W-1:0];
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_mode  <= 2'b00;
            r_win   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_om    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_cnt <= '0;
                        r_acc <= '0;
                    end else if (in_valid) begin
                        r_mode <= mode;
                        r_win  <= w_win_clamp;
                        r_acc  <= w_acc_next;
                        if (w_win_clamp == '0) begin
                            r_state <= S_OUT;
                            r_cnt   <= '0;
                            r_om    <= w_result;
                        end else begin
                            r_state <= S_ACCUM;
                            r_cnt   <= CNT_W'(1);
                        end
                    end
                end
                S_ACCUM: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                    end else if (in_valid) begin
                        r_acc <= w_acc_next;
                        // Exit is tested before the increment, so the
                        // counter never needs to represent more than 2^MAX.
                        if ((r_cnt + CNT_W'(1)) == (CNT_W'(1) << r_win)) begin
                            r_state <= S_OUT;
                            r_cnt   <= '0;
                            r_om    <= w_result;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                        r_acc   <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_acc   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state != S_OUT);
    assign out_valid = (r_state == S_OUT);
    assign om        = r_om;
    assign state     = r_state;

endmodule
`default_nettype wire
